// File: rtl/ccff_bitstream_loader.sv
// Serialises parallel configuration words onto a ccff chain head, optionally
// comparing the bits returning on the chain tail and counting mismatches.
//
// state     | meaning
// IDLE      | no pass in progress
// WAIT_WORD | requesting the next configuration word
// SHIFT     | shifting the current word out, one bit per cycle
// DONE      | one-cycle completion pulse
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8,
    parameter int ERR_W     = 8
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              mode_verify,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count
);

    localparam int TOT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = $clog2(WORD_W + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_WORD = 2'd1;
    localparam logic [1:0] S_SHIFT     = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    localparam logic [TOT_W-1:0] TOT_LAST = TOT_W'(CHAIN_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    logic [1:0]        state_q;
    logic              mode_q;
    logic [WORD_W-1:0] shift_buf_q;
    logic [IDX_W-1:0]  word_idx_q;
    logic [TOT_W-1:0]  total_q;
    logic [ERR_W-1:0]  err_q;

    logic [TOT_W-1:0]  total_nxt;
    logic [IDX_W-1:0]  word_idx_nxt;
    logic              mismatch;

    assign total_nxt    = total_q + TOT_W'(1);
    assign word_idx_nxt = word_idx_q + IDX_W'(1);
    assign mismatch     = mode_q && (ccff_tail != shift_buf_q[0]);

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            shift_buf_q <= '0;
            word_idx_q  <= '0;
            total_q     <= '0;
            err_q       <= '0;
        end else if (abort) begin
            // abort also suppresses a start arriving in the same IDLE cycle
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_WAIT_WORD;
                        mode_q  <= mode_verify;
                        err_q   <= '0;
                        total_q <= '0;
                    end
                end
                S_WAIT_WORD: begin
                    if (cfg_valid) begin
                        shift_buf_q <= cfg_data;
                        word_idx_q  <= '0;
                        state_q     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shift_buf_q <= shift_buf_q >> 1;
                    word_idx_q  <= word_idx_nxt;
                    total_q     <= total_nxt;
                    if (mismatch && (err_q != ERR_MAX)) begin
                        err_q <= err_q + ERR_W'(1);
                    end
                    // chain-length limit wins so trailing bits of the last word are dropped
                    if (total_nxt == TOT_LAST) begin
                        state_q <= S_DONE;
                    end else if (word_idx_nxt == IDX_LAST) begin
                        state_q <= S_WAIT_WORD;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = (state_q == S_WAIT_WORD);
    assign shift_en  = (state_q == S_SHIFT);
    assign ccff_head = shift_en & shift_buf_q[0];
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err_count = err_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: chain model plus bitstream-level reference,
// directed scenarios and randomized passes on two instances (ERR_W 8 and 2).
module tb_ccff_bitstream_loader;

    localparam int CL = 20;
    localparam int WW = 8;
    localparam int NW = (CL + WW - 1) / WW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic mode_verify = 1'b0;
    logic abort = 1'b0;
    logic cfg_valid = 1'b0;
    logic [WW-1:0] cfg_data = '0;

    logic ready_a, head_a, sh_a, busy_a, done_a;
    logic [7:0] err_a;
    logic ready_b, head_b, sh_b, busy_b, done_b;
    logic [1:0] err_b;

    logic [CL-1:0] chain_a = '0;
    logic [CL-1:0] chain_b = '0;

    always #5 clk = ~clk;

    ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .ERR_W(8)) dut_a (
        .prog_clk(clk), .pReset_n(rst_n), .start(start), .mode_verify(mode_verify),
        .abort(abort), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_a),
        .ccff_head(head_a), .shift_en(sh_a), .ccff_tail(chain_a[CL-1]), .busy(busy_a),
        .done(done_a), .err_count(err_a));

    ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .ERR_W(2)) dut_b (
        .prog_clk(clk), .pReset_n(rst_n), .start(start), .mode_verify(mode_verify),
        .abort(abort), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_b),
        .ccff_head(head_b), .shift_en(sh_b), .ccff_tail(chain_b[CL-1]), .busy(busy_b),
        .done(done_b), .err_count(err_b));

    // external configuration chains: newest bit at index 0, tail at CL-1
    always @(posedge clk) begin
        if (sh_a) chain_a <= {chain_a[CL-2:0], head_a};
        if (sh_b) chain_b <= {chain_b[CL-2:0], head_b};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // reference state for the pass in flight
    logic [WW-1:0] words [NW];
    bit   exp_bits [CL];
    bit   head_seq [CL];
    bit   pass_active = 0;
    int   bit_i, ready_cnt, done_cnt, done_cyc, last_delay;

    always @(negedge clk) begin
        if (pass_active && rst_n) begin
            check("shift_en_b_vs_a", sh_b, sh_a);
            check("ready_shift_exclusive", ready_a & sh_a, 0);
            if (sh_a | ready_a | done_a) check("busy_in_pass", busy_a, 1);
            if (sh_a) begin
                if (bit_i < CL) begin
                    check("head_bit", head_a, exp_bits[bit_i]);
                    check("head_bit_b", head_b, exp_bits[bit_i]);
                    head_seq[bit_i] = head_a;
                end else begin
                    check("shift_overrun", bit_i, CL - 1);
                end
                bit_i++;
            end
            if (ready_a) ready_cnt++;
            if (done_a) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run_pass(input bit vfy, input int stall0, input int stall1, input int stall2,
                            input int abort_at, input bit noise);
        int st [NW];
        int k, stall_total, raw_a, raw_b, s_edge, seen_shift, budget;
        bit got_done, aborted;
        logic [CL-1:0] snap_a, snap_b, exp_chain;
        st[0] = stall0; st[1] = stall1; st[2] = stall2;
        for (int i = 0; i < CL; i++) exp_bits[i] = words[i / WW][i % WW];
        snap_a = chain_a;
        snap_b = chain_b;
        raw_a = 0;
        raw_b = 0;
        for (int i = 0; i < CL; i++) begin
            if (exp_bits[i] != snap_a[CL-1-i]) raw_a++;
            if (exp_bits[i] != snap_b[CL-1-i]) raw_b++;
        end
        bit_i = 0; ready_cnt = 0; done_cnt = 0; done_cyc = -1;
        pass_active = 1;
        @(negedge clk);
        start = 1'b1;
        mode_verify = vfy;
        @(negedge clk);
        start = 1'b0;
        mode_verify = 1'($urandom);
        s_edge = cyc;
        k = 0; stall_total = 0; seen_shift = 0; got_done = 0; aborted = 0;
        for (budget = 0; budget < 300; budget++) begin
            if (budget > 0) @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            if (aborted) begin
                check("abort_shift_en_low", sh_a, 0);
                check("abort_busy_low", busy_a, 0);
                check("abort_ready_low", ready_a, 0);
                break;
            end
            if (done_a) begin
                got_done = 1;
                cfg_valid = 1'b0;
                break;
            end
            if (noise && busy_a) start = 1'($urandom);
            if (sh_a) begin
                seen_shift++;
                if (seen_shift == abort_at) begin
                    abort = 1'b1;
                    aborted = 1;
                end
            end
            if (k < NW && st[k] > 0 && ready_a) begin
                cfg_valid = 1'b0;
                st[k]--;
                stall_total++;
            end else if (k < NW && st[k] == 0) begin
                cfg_valid = 1'b1;
                cfg_data = words[k];
                if (ready_a) k++;
            end else begin
                cfg_valid = 1'b0;
                cfg_data = WW'($urandom);
            end
        end
        cfg_valid = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        if (abort_at > 0) begin
            repeat (3) @(negedge clk);
            check("abort_no_done", done_cnt, 0);
            check("abort_shift_count", bit_i, abort_at);
            check("abort_err_hold", err_a, 0);
            exp_chain = snap_a << abort_at;
            for (int j = 0; j < abort_at; j++) exp_chain[abort_at-1-j] = exp_bits[j];
            check("abort_chain", chain_a, exp_chain);
        end else begin
            if (!got_done) check("done_timeout", 0, 1);
            @(negedge clk);
            last_delay = done_cyc - s_edge;
            check("shift_count", bit_i, CL);
            check("ready_cycles", ready_cnt, NW + stall_total);
            check("done_pulses", done_cnt, 1);
            check("done_delay", last_delay, NW + stall_total + CL);
            check("err_count_a", err_a, vfy ? sat(raw_a, 255) : 0);
            check("err_count_b", err_b, vfy ? sat(raw_b, 3) : 0);
            for (int i = 0; i < CL; i++) exp_chain[CL-1-i] = exp_bits[i];
            check("chain_contents", chain_a, exp_chain);
            check("idle_after_done", busy_a, 0);
        end
        pass_active = 0;
    endtask

    task automatic set_words(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                             input logic [WW-1:0] w2);
        words[0] = w0; words[1] = w1; words[2] = w2;
    endtask

    task automatic check_lit_heads(input string name);
        int lit [CL];
        lit = '{1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1};
        for (int i = 0; i < CL; i++) check(name, head_seq[i], lit[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ab;
        repeat (3) @(negedge clk);
        check("rst_ready", ready_a, 0);
        check("rst_head", head_a, 0);
        check("rst_shift_en", sh_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy_a, 0);

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle_busy", busy_a, 0);
        check("start_abort_idle_ready", ready_a, 0);

        set_words(8'hA5, 8'h3C, 8'h0F);
        run_pass(0, 0, 0, 0, 0, 0);
        check_lit_heads("lit_head_load");
        check("lit_done_delay", last_delay, 23);

        run_pass(1, 0, 0, 0, 0, 0);
        check("lit_verify_same_err", err_a, 0);

        set_words(8'hA4, 8'h3C, 8'h0F);
        run_pass(1, 0, 0, 0, 0, 0);
        check("lit_verify_one_err", err_a, 1);

        set_words(8'hA5, 8'h3C, 8'h0F);
        run_pass(0, 0, 5, 0, 0, 0);
        check_lit_heads("lit_head_backpressure");
        check("lit_done_delay_bp", last_delay, 28);

        run_pass(0, 0, 0, 0, 3, 0);
        run_pass(0, 0, 0, 0, 0, 1);

        // asynchronous reset in the middle of shifting
        set_words(8'h5A, 8'hC3, 8'hF0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = words[0];
        for (int i = 0; i < 10 && !sh_a; i++) @(negedge clk);
        check("reached_shift", sh_a, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready", ready_a, 0);
        check("async_rst_head", head_a, 0);
        check("async_rst_shift_en", sh_a, 0);
        check("async_rst_busy", busy_a, 0);
        check("async_rst_done", done_a, 0);
        check("async_rst_err", err_a, 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_async_rst_idle", busy_a, 0);

        // saturation: zeros loaded, ones verified
        set_words(8'h00, 8'h00, 8'h00);
        run_pass(0, 0, 0, 0, 0, 0);
        set_words(8'hFF, 8'hFF, 8'hFF);
        run_pass(1, 0, 0, 0, 0, 0);
        check("lit_sat_err_b", err_b, 3);
        check("lit_sat_err_a", err_a, 20);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0)
                set_words(WW'($urandom), WW'($urandom), WW'($urandom));
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, CL - 1)) : 0;
            run_pass((ab == 0) ? 1'($urandom) : 1'b0,
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     ab, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
